// File: rtl/instr_fetch_unit.sv
// PC / fetch stage in front of a word-addressed instruction memory.
// It registers the fetched word with its PC, applies branch and jump redirects, and halts on request or on a PC fault.
module instr_fetch_unit #(
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 128,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              halt,
   input  logic              branch_taken,
   input  logic [15:0]       branch_offset,
   input  logic              jump,
   input  logic [25:0]       jump_target,
   output logic              imem_memread,
   output logic [ADDR_W-1:0] imem_address,
   input  logic [31:0]       imem_readdata,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   output logic              fault
);

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              fault_q, fault_d;

   logic [ADDR_W:0]   seq_pc_ext;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] jmp_target;
   logic [ADDR_W-1:0] redir_target;
   logic              redirect;
   logic              unused_hi_bits;

   assign unused_hi_bits = ^{jump_target[25:ADDR_W], branch_offset[15:ADDR_W]};

   // Branch offset is truncated to the PC width, so modular addition covers negative offsets.
   assign seq_pc_ext   = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};
   assign br_target    = instr_pc_q + PC_ONE + branch_offset[ADDR_W-1:0];
   assign jmp_target   = jump_target[ADDR_W-1:0];
   assign redir_target = jump ? jmp_target : br_target;
   assign redirect     = instr_valid_q & (jump | branch_taken);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC_W;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fault_d       = fault_q;
      case (state_q)
         IDLE: begin
            state_d = RUN;
         end
         RUN: begin
            if (en) begin
               if (halt) begin
                  state_d       = HALTED;
                  instr_valid_d = 1'b0;
               end else if (redirect) begin
                  // The word fetched at the old PC is dropped; an out-of-range target faults and leaves pc unchanged.
                  instr_valid_d = 1'b0;
                  if ({1'b0, redir_target} >= DEPTH_W) begin
                     state_d = HALTED;
                     fault_d = 1'b1;
                  end else begin
                     pc_d = redir_target;
                  end
               end else begin
                  instr_d       = imem_readdata;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  if (seq_pc_ext >= DEPTH_W) begin
                     state_d = HALTED;
                     fault_d = 1'b1;
                  end else begin
                     pc_d = seq_pc_ext[ADDR_W-1:0];
                  end
               end
            end
         end
         HALTED: begin
            instr_valid_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign imem_memread = (state_q == RUN);
   assign imem_address = pc_q;
   assign pc           = pc_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign instr_valid  = instr_valid_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by randomized traffic.
// Every output is checked against a behavioural fetch model kept in this file.
module tb_instr_fetch_unit;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 128;
   localparam int PCMOD  = 1 << ADDR_W;

   logic              clk;
   logic              rst;
   logic              en;
   logic              halt;
   logic              branch_taken;
   logic [15:0]       branch_offset;
   logic              jump;
   logic [25:0]       jump_target;
   logic              imem_memread;
   logic [ADDR_W-1:0] imem_address;
   logic [31:0]       imem_readdata;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              fault;

   logic [31:0] mem [0:PCMOD-1];

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   bit          m_started;
   bit          m_halted;
   int          m_pc;
   logic [31:0] m_instr;
   int          m_ipc;
   bit          m_valid;
   bit          m_fault;

   instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .halt          (halt),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_memread  (imem_memread),
      .imem_address  (imem_address),
      .imem_readdata (imem_readdata),
      .pc            (pc),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .fault         (fault)
   );

   assign imem_readdata = mem[imem_address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      check({ctx, ":pc"},       {24'h0, pc},                 32'(m_pc));
      check({ctx, ":addr"},     {24'h0, imem_address},       32'(m_pc));
      check({ctx, ":memread"},  {31'h0, imem_memread},       32'(m_started && !m_halted));
      check({ctx, ":instr"},    instr,                       m_instr);
      check({ctx, ":instr_pc"}, {24'h0, instr_pc},           32'(m_ipc));
      check({ctx, ":valid"},    {31'h0, instr_valid},        32'(m_valid));
      check({ctx, ":fault"},    {31'h0, fault},              32'(m_fault));
   endtask

   task automatic model_reset();
      m_started = 0; m_halted = 0; m_pc = 0;
      m_instr = '0; m_ipc = 0; m_valid = 0; m_fault = 0;
   endtask

   // One clock of the fetch rules, evaluated on the inputs present before the edge.
   task automatic model_clock();
      int t;
      if (!m_started) begin
         m_started = 1;
      end else if (m_halted) begin
         m_valid = 0;
      end else if (en) begin
         if (halt) begin
            m_halted = 1;
            m_valid  = 0;
         end else if (m_valid && (jump || branch_taken)) begin
            if (jump) t = int'(jump_target) % PCMOD;
            else      t = m_ipc + 1 + int'($signed(branch_offset));
            t = ((t % PCMOD) + PCMOD) % PCMOD;
            m_valid = 0;
            if (t >= DEPTH) begin
               m_halted = 1;
               m_fault  = 1;
            end else begin
               m_pc = t;
            end
         end else begin
            m_instr = mem[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            if (m_pc + 1 >= DEPTH) begin
               m_halted = 1;
               m_fault  = 1;
            end else begin
               m_pc = m_pc + 1;
            end
         end
      end
   endtask

   task automatic step(input string ctx);
      model_clock();
      @(posedge clk);
      #1;
      check_all(ctx);
   endtask

   task automatic idle_inputs();
      en = 1'b1; halt = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_offset = 16'h0; jump_target = 26'h0;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string ctx);
      @(posedge clk);
      #2 rst = 1'b1;
      model_reset();
      #1 check_all(ctx);
      #1 rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < PCMOD; i++) mem[i] = $urandom;
      mem[0] = 32'h20100000;
      mem[1] = 32'h200D0003;
      mem[2] = 32'hAE0D0000;
      idle_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all("reset");
      #2 rst = 1'b0;

      // First three words in order, after one IDLE bubble.
      step("idle_bubble");
      for (int i = 0; i < 3; i++) step("seq_start");
      check("first_word_seen", instr, 32'hAE0D0000);

      while (m_ipc != 26 || !m_valid) step("seq_to26");
      branch_taken = 1'b1; branch_offset = 16'd11;
      step("branch_fwd");
      check("branch_fwd_pc", {24'h0, pc}, 32'd38);
      idle_inputs();
      step("after_branch");
      check("after_branch_ipc", {24'h0, instr_pc}, 32'd38);

      jump = 1'b1; jump_target = 26'h010001A;
      step("jump");
      check("jump_pc", {24'h0, pc}, 32'd26);
      idle_inputs();
      step("after_jump");

      branch_taken = 1'b1; branch_offset = 16'hFFEA;
      step("branch_to5");
      idle_inputs();
      step("at5");
      branch_taken = 1'b1; branch_offset = 16'hFFFD;
      step("branch_back");
      check("branch_back_pc", {24'h0, pc}, 32'd3);
      idle_inputs();
      step("after_back");

      jump = 1'b1; jump_target = 26'd100; branch_taken = 1'b1; branch_offset = 16'd1;
      step("jump_wins");
      check("jump_wins_pc", {24'h0, pc}, 32'd100);
      idle_inputs();
      step("after_both");
      step("run");

      en = 1'b0;
      repeat (3) step("stall");
      en = 1'b1;
      repeat (3) step("resume");

      // Sequential run off the end of memory.
      async_reset("rst_before_end");
      idle_inputs();
      repeat (132) step("run_to_end");
      check("end_fault", {31'h0, fault}, 32'd1);
      check("end_last_ipc", {24'h0, instr_pc}, 32'd127);

      // Halt request.
      async_reset("rst_before_halt");
      repeat (5) step("pre_halt");
      halt = 1'b1;
      step("halt");
      halt = 1'b0;
      repeat (3) step("halted");
      check("halt_no_fault", {31'h0, fault}, 32'd0);

      // Asynchronous reset mid-run and restart.
      async_reset("rst_from_halted");
      repeat (6) step("run2");
      async_reset("rst_midrun");
      repeat (4) step("restart");

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         en            = ($urandom_range(0, 9) != 0);
         halt          = ($urandom_range(0, 199) == 0);
         branch_taken  = ($urandom_range(0, 5) == 0);
         jump          = ($urandom_range(0, 9) == 0);
         branch_offset = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40) - 20);
         jump_target   = 26'($urandom);
         if (m_halted && $urandom_range(0, 3) == 0) async_reset("rand_rst");
         else step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
